vec_pipe_core: RTL and testbench

Parametrised 4-stage vector execution core (Decode-read, Execute, Memory, Write-back) for the vector CPU. It holds its own vector register file and runs a lane-parallel ALU with immediate broadcast and load/store address generation. Unlike the first-generation datapath, it is generic in lane count, lane width and register count. It adds full E-stage operand forwarding, load-use stall generation and an E-stage flush. It sits between the control/decode unit, which drives `dec_*`, and the vector data memory.

---
 rtl/vec_pipe_core.sv | 219 +++++++++++++++++++++
 tb/tb_vec_pipe_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_pipe_core.sv
// vec_pipe_core: 4-stage (D/E/M/W) lane-parallel vector execution core.
// Holds its own vector register file, forwards M/W results into E,
// raises a one-cycle load-use stall and can flush the instruction entering E.
module vec_pipe_core #(
  parameter int  LANES = 6,
  parameter int  W     = 8,
  parameter int  NREG  = 16,
  parameter int  AW    = 32,
  localparam int RA    = $clog2(NREG),
  localparam int DW    = LANES * W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec_valid,
  input  logic [2:0]    dec_op,
  input  logic [RA-1:0] dec_ra1,
  input  logic [RA-1:0] dec_ra2,
  input  logic [RA-1:0] dec_wa,
  input  logic [W-1:0]  dec_imm,
  input  logic          dec_use_imm,
  input  logic          dec_regwrite,
  input  logic          dec_memread,
  input  logic          dec_memwrite,
  input  logic          flush,
  output logic          stall_o,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic [RA-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic [1:0]    flags_o
);
  localparam int SW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  logic          e_valid_q, e_valid_d, e_use_imm_q, e_use_imm_d;
  logic          e_regwrite_q, e_regwrite_d, e_memread_q, e_memread_d;
  logic          e_memwrite_q, e_memwrite_d;
  logic [2:0]    e_op_q, e_op_d;
  logic [RA-1:0] e_ra1_q, e_ra1_d, e_ra2_q, e_ra2_d, e_wa_q, e_wa_d;
  logic [W-1:0]  e_imm_q, e_imm_d;
  logic [DW-1:0] e_rd1_q, e_rd1_d, e_rd2_q, e_rd2_d;

  logic          m_valid_q, m_valid_d, m_regwrite_q, m_regwrite_d;
  logic          m_memread_q, m_memread_d, m_memwrite_q, m_memwrite_d;
  logic [RA-1:0] m_wa_q, m_wa_d;
  logic [DW-1:0] m_alu_q, m_alu_d, m_wdata_q, m_wdata_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [1:0]    m_flags_q, m_flags_d;

  logic          w_we_q, w_we_d;
  logic [RA-1:0] w_wa_q, w_wa_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [1:0]    flags_q, flags_d;

  logic [DW-1:0] rd1, rd2, op_a, fwd_b, op_b, alu_res;
  logic [W-1:0]  lane_a, lane_b, lane_r;
  logic          alu_c, alu_z;

  // D-stage register read with write-first bypass of the W-stage write
  always_comb begin
    rd1 = rf_q[dec_ra1];
    rd2 = rf_q[dec_ra2];
    if (w_we_q && (w_wa_q == dec_ra1)) rd1 = w_data_q;
    if (w_we_q && (w_wa_q == dec_ra2)) rd2 = w_data_q;
  end

  // Load-use hazard: a register-writing load in E feeds a source in D
  always_comb begin
    stall_o = dec_valid & e_valid_q & e_memread_q & e_regwrite_q &
              ((e_wa_q == dec_ra1) | (!dec_use_imm & (e_wa_q == dec_ra2)));
  end

  // E-stage capture; stalls and flushes load an all-zero bubble
  always_comb begin
    e_valid_d    = 1'b0;
    e_op_d       = '0;
    e_ra1_d      = '0;
    e_ra2_d      = '0;
    e_wa_d       = '0;
    e_imm_d      = '0;
    e_use_imm_d  = 1'b0;
    e_regwrite_d = 1'b0;
    e_memread_d  = 1'b0;
    e_memwrite_d = 1'b0;
    e_rd1_d      = '0;
    e_rd2_d      = '0;
    if (dec_valid && !stall_o && !flush) begin
      e_valid_d    = 1'b1;
      e_op_d       = dec_op;
      e_ra1_d      = dec_ra1;
      e_ra2_d      = dec_ra2;
      e_wa_d       = dec_wa;
      e_imm_d      = dec_imm;
      e_use_imm_d  = dec_use_imm;
      e_regwrite_d = dec_regwrite;
      e_memread_d  = dec_memread;
      e_memwrite_d = dec_memwrite;
      e_rd1_d      = rd1;
      e_rd2_d      = rd2;
    end
  end

  // E-stage operand selection: M result beats W result beats the D read
  always_comb begin
    op_a = e_rd1_q;
    if (m_valid_q && m_regwrite_q && !m_memread_q && (m_wa_q == e_ra1_q)) op_a = m_alu_q;
    else if (w_we_q && (w_wa_q == e_ra1_q))                               op_a = w_data_q;
    fwd_b = e_rd2_q;
    if (m_valid_q && m_regwrite_q && !m_memread_q && (m_wa_q == e_ra2_q)) fwd_b = m_alu_q;
    else if (w_we_q && (w_wa_q == e_ra2_q))                               fwd_b = w_data_q;
    op_b = e_use_imm_q ? {LANES{e_imm_q}} : fwd_b;
  end

  // Lane-parallel ALU plus lane-0 carry/borrow and all-lanes-zero flag
  always_comb begin
    alu_res = '0;
    lane_a  = '0;
    lane_b  = '0;
    lane_r  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = op_a[i*W +: W];
      lane_b = op_b[i*W +: W];
      case (e_op_q)
        OP_ADD:  lane_r = lane_a + lane_b;
        OP_SUB:  lane_r = lane_a - lane_b;
        OP_AND:  lane_r = lane_a & lane_b;
        OP_OR:   lane_r = lane_a | lane_b;
        OP_XOR:  lane_r = lane_a ^ lane_b;
        OP_SHL:  lane_r = lane_a << e_imm_q[SW-1:0];
        OP_SHR:  lane_r = lane_a >> e_imm_q[SW-1:0];
        default: lane_r = lane_b;
      endcase
      alu_res[i*W +: W] = lane_r;
    end
    case (e_op_q)
      OP_ADD:  alu_c = alu_res[W-1:0] < op_a[W-1:0];
      OP_SUB:  alu_c = op_a[W-1:0] < op_b[W-1:0];
      default: alu_c = 1'b0;
    endcase
    alu_z = (alu_res == '0);
  end

  // M-stage capture; a bubble in E clears every M field so memory outputs idle at zero
  always_comb begin
    m_valid_d    = e_valid_q;
    m_regwrite_d = e_valid_q & e_regwrite_q;
    m_memread_d  = e_valid_q & e_memread_q;
    m_memwrite_d = e_valid_q & e_memwrite_q;
    m_wa_d       = e_valid_q ? e_wa_q : '0;
    m_alu_d      = e_valid_q ? alu_res : '0;
    m_wdata_d    = e_valid_q ? fwd_b : '0;
    m_addr_d     = e_valid_q ? (op_a[AW-1:0] + AW'(e_imm_q)) : '0;
    m_flags_d    = e_valid_q ? {alu_z, alu_c} : 2'b00;
  end

  // W-stage capture: load data or ALU result; flags retire with non-memory ops
  always_comb begin
    w_we_d   = m_valid_q & m_regwrite_q;
    w_wa_d   = m_valid_q ? m_wa_q : '0;
    w_data_d = '0;
    if (m_valid_q) w_data_d = m_memread_q ? mem_rdata : m_alu_q;
    flags_d  = flags_q;
    if (m_valid_q && !m_memread_q && !m_memwrite_q) flags_d = m_flags_q;
  end

  // Register file write from the committing W-stage instruction
  always_comb begin
    rf_d = rf_q;
    if (w_we_q) rf_d[w_wa_q] = w_data_q;
  end

  // Pipeline, flag and register-file state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q <= 1'b0;  e_op_q <= '0;  e_ra1_q <= '0;  e_ra2_q <= '0;
      e_wa_q <= '0;  e_imm_q <= '0;  e_use_imm_q <= 1'b0;  e_regwrite_q <= 1'b0;
      e_memread_q <= 1'b0;  e_memwrite_q <= 1'b0;  e_rd1_q <= '0;  e_rd2_q <= '0;
      m_valid_q <= 1'b0;  m_regwrite_q <= 1'b0;  m_memread_q <= 1'b0;
      m_memwrite_q <= 1'b0;  m_wa_q <= '0;  m_alu_q <= '0;  m_wdata_q <= '0;
      m_addr_q <= '0;  m_flags_q <= 2'b00;
      w_we_q <= 1'b0;  w_wa_q <= '0;  w_data_q <= '0;  flags_q <= 2'b00;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      e_valid_q <= e_valid_d;  e_op_q <= e_op_d;  e_ra1_q <= e_ra1_d;  e_ra2_q <= e_ra2_d;
      e_wa_q <= e_wa_d;  e_imm_q <= e_imm_d;  e_use_imm_q <= e_use_imm_d;
      e_regwrite_q <= e_regwrite_d;  e_memread_q <= e_memread_d;
      e_memwrite_q <= e_memwrite_d;  e_rd1_q <= e_rd1_d;  e_rd2_q <= e_rd2_d;
      m_valid_q <= m_valid_d;  m_regwrite_q <= m_regwrite_d;  m_memread_q <= m_memread_d;
      m_memwrite_q <= m_memwrite_d;  m_wa_q <= m_wa_d;  m_alu_q <= m_alu_d;
      m_wdata_q <= m_wdata_d;  m_addr_q <= m_addr_d;  m_flags_q <= m_flags_d;
      w_we_q <= w_we_d;  w_wa_q <= w_wa_d;  w_data_q <= w_data_d;  flags_q <= flags_d;
      rf_q <= rf_d;
    end
  end

  assign mem_re    = m_valid_q & m_memread_q;
  assign mem_we    = m_valid_q & m_memwrite_q;
  assign mem_addr  = m_addr_q;
  assign mem_wdata = m_wdata_q;
  assign wb_valid  = w_we_q;
  assign wb_addr   = w_wa_q;
  assign wb_data   = w_data_q;
  assign flags_o   = flags_q;

endmodule

// File: tb/tb_vec_pipe_core.sv
// tb_vec_pipe_core: directed self-checking bench for vec_pipe_core with an
// in-order architectural model and a per-cycle compare process.
module tb_vec_pipe_core;
  localparam int LANES = 6;
  localparam int W     = 8;
  localparam int NREG  = 16;
  localparam int AW    = 32;
  localparam int RA    = 4;
  localparam int DW    = LANES * W;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR_ = 3'd4, MOV = 3'd7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dec_valid = 1'b0;
  logic [2:0]    dec_op = '0;
  logic [RA-1:0] dec_ra1 = '0, dec_ra2 = '0, dec_wa = '0;
  logic [W-1:0]  dec_imm = '0;
  logic          dec_use_imm = 1'b0, dec_regwrite = 1'b0;
  logic          dec_memread = 1'b0, dec_memwrite = 1'b0;
  logic          flush = 1'b0;
  logic          stall_o, mem_re, mem_we, wb_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, wb_data;
  logic [RA-1:0] wb_addr;
  logic [1:0]    flags_o;

  vec_pipe_core dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_op(dec_op),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_wa(dec_wa), .dec_imm(dec_imm),
    .dec_use_imm(dec_use_imm), .dec_regwrite(dec_regwrite),
    .dec_memread(dec_memread), .dec_memwrite(dec_memwrite), .flush(flush),
    .stall_o(stall_o), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  // Read-only data memory: every lane returns the low address byte XOR 0x23
  assign mem_rdata = {LANES{mem_addr[7:0] ^ 8'h23}};

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state and cycle-keyed expectations
  typedef struct packed { logic [RA-1:0] wa; logic [DW-1:0] data; } wb_t;
  typedef struct packed { logic re; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_t;
  logic [DW-1:0] mreg [NREG];
  wb_t           wb_sched [int];
  mem_t          mem_sched [int];
  logic [1:0]    fl_sched [int];
  logic [1:0]    exp_flags = 2'b00;
  logic          pe_load = 1'b0;
  logic [RA-1:0] pe_wa = '0;
  logic          consumed = 1'b0;
  int            cyc = 0;

  // Observations of the DUT used by the literal checks
  int            stall_cnt = 0, commit_cnt = 0;
  logic [NREG-1:0] commit_mask = '0;
  logic [DW-1:0] obs [NREG];
  logic [AW-1:0] obs_rd_addr = '1, obs_st_addr = '1;
  logic [DW-1:0] obs_st_data = '1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void model_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [W-1:0] imm, output logic [DW-1:0] r, output logic [1:0] fl);
    int x, y, v, sh, m;
    logic c;
    m  = 1 << W;
    sh = int'(imm) % W;
    r  = '0;
    for (int i = 0; i < LANES; i++) begin
      x = int'(a[i*W +: W]);
      y = int'(b[i*W +: W]);
      case (op)
        3'd0:    v = (x + y) % m;
        3'd1:    v = (x - y + m) % m;
        3'd2:    v = x & y;
        3'd3:    v = x | y;
        3'd4:    v = x ^ y;
        3'd5:    v = (x << sh) % m;
        3'd6:    v = x >> sh;
        default: v = y;
      endcase
      r[i*W +: W] = v[W-1:0];
    end
    x = int'(a[W-1:0]);
    y = int'(b[W-1:0]);
    c = (op == 3'd0) ? ((x + y) >= m) : (op == 3'd1) ? (x < y) : 1'b0;
    fl = {(r == '0), c};
  endfunction

  // Per-cycle compare against the model, then advance the model with the D-stage input
  always @(negedge clk) begin : mon
    logic exp_stall, acc;
    logic [DW-1:0] a, breg, b, res;
    logic [1:0] fl;
    logic [AW-1:0] addr;
    exp_stall = dec_valid && pe_load && ((pe_wa == dec_ra1) || (!dec_use_imm && (pe_wa == dec_ra2)));
    checkOutput("stall_o", stall_o, exp_stall);
    if (fl_sched.exists(cyc)) begin
      exp_flags = fl_sched[cyc];
      fl_sched.delete(cyc);
    end
    checkOutput("flags_o", flags_o, exp_flags);
    if (mem_sched.exists(cyc)) begin
      checkOutput("mem_re", mem_re, mem_sched[cyc].re);
      checkOutput("mem_we", mem_we, mem_sched[cyc].we);
      checkOutput("mem_addr", mem_addr, mem_sched[cyc].addr);
      if (mem_sched[cyc].we) checkOutput("mem_wdata", mem_wdata, mem_sched[cyc].wdata);
      mem_sched.delete(cyc);
    end else begin
      checkOutput("mem_re_idle", mem_re, 1'b0);
      checkOutput("mem_we_idle", mem_we, 1'b0);
    end
    if (wb_sched.exists(cyc)) begin
      checkOutput("wb_valid", wb_valid, 1'b1);
      checkOutput("wb_addr", wb_addr, wb_sched[cyc].wa);
      checkOutput("wb_data", wb_data, wb_sched[cyc].data);
      wb_sched.delete(cyc);
    end else begin
      checkOutput("wb_valid_idle", wb_valid, 1'b0);
    end
    if (stall_o) stall_cnt++;
    if (wb_valid) begin
      commit_cnt++;
      commit_mask[wb_addr] = 1'b1;
      obs[wb_addr] = wb_data;
    end
    if (mem_re) obs_rd_addr = mem_addr;
    if (mem_we) begin
      obs_st_addr = mem_addr;
      obs_st_data = mem_wdata;
    end
    acc      = dec_valid && !exp_stall && !flush && !reset;
    consumed = dec_valid && !exp_stall;
    pe_load  = 1'b0;
    if (reset) begin
      foreach (mreg[i]) mreg[i] = '0;
      wb_sched.delete();
      mem_sched.delete();
      fl_sched.delete();
      exp_flags = 2'b00;
    end else if (acc) begin
      a    = mreg[dec_ra1];
      breg = mreg[dec_ra2];
      b    = dec_use_imm ? {LANES{dec_imm}} : breg;
      model_alu(dec_op, a, b, dec_imm, res, fl);
      addr = a[AW-1:0] + AW'(dec_imm);
      if (dec_memread || dec_memwrite) mem_sched[cyc+2] = '{dec_memread, dec_memwrite, addr, breg};
      else fl_sched[cyc+3] = fl;
      if (dec_regwrite) begin
        if (dec_memread) res = {LANES{addr[7:0] ^ 8'h23}};
        mreg[dec_wa] = res;
        wb_sched[cyc+3] = '{dec_wa, res};
      end
      pe_load = dec_memread && dec_regwrite;
      pe_wa   = dec_wa;
    end
    cyc++;
  end

  // Present one instruction and hold it until the pipe takes it; flush covers the first presentation only
  task automatic applyStimulus(input logic [2:0] op, input logic [RA-1:0] ra1, input logic [RA-1:0] ra2,
                               input logic [RA-1:0] wa, input logic [W-1:0] imm, input logic use_imm,
                               input logic rw, input logic mr, input logic mw, input logic fl);
    int guard = 0;
    dec_valid = 1'b1;  dec_op = op;  dec_ra1 = ra1;  dec_ra2 = ra2;  dec_wa = wa;
    dec_imm = imm;  dec_use_imm = use_imm;  dec_regwrite = rw;
    dec_memread = mr;  dec_memwrite = mw;  flush = fl;
    do begin
      @(posedge clk); #1;
      flush = 1'b0;
      guard++;
    end while (!consumed && guard < 8);
    checkOutput("issue_accept", consumed, 1'b1);
    dec_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    dec_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    foreach (obs[i]) obs[i] = '1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", stall_o, 1'b0);
    checkOutput("rst_wb_valid", wb_valid, 1'b0);
    checkOutput("rst_flags", flags_o, 2'b00);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_wb_data", wb_data, 48'h0);
    reset = 1'b0;

    $display("[TB] forwarding chain");
    stall_cnt = 0;
    applyStimulus(MOV, 4'd0, 4'd0, 4'd1, 8'h7F, 1, 1, 0, 0, 0);
    applyStimulus(ADD, 4'd1, 4'd1, 4'd2, 8'h00, 0, 1, 0, 0, 0);
    applyStimulus(ADD, 4'd2, 4'd1, 4'd3, 8'h00, 0, 1, 0, 0, 0);
    idle(5);
    checkOutput("chain_r2", obs[2], {LANES{8'hFE}});
    checkOutput("chain_r3", obs[3], {LANES{8'h7D}});
    checkOutput("chain_flags", flags_o, 2'b01);
    checkOutput("chain_stalls", stall_cnt, 0);

    $display("[TB] wrap and flags");
    applyStimulus(MOV, 4'd0, 4'd0, 4'd1, 8'h01, 1, 1, 0, 0, 0);
    applyStimulus(SUB, 4'd0, 4'd1, 4'd2, 8'h00, 0, 1, 0, 0, 0);
    idle(5);
    checkOutput("wrap_r2", obs[2], {LANES{8'hFF}});
    checkOutput("wrap_flags", flags_o, 2'b01);
    applyStimulus(XOR_, 4'd2, 4'd2, 4'd3, 8'h00, 0, 1, 0, 0, 0);
    idle(5);
    checkOutput("xor_r3", obs[3], 48'h0);
    checkOutput("xor_flags", flags_o, 2'b10);

    $display("[TB] load-use");
    stall_cnt = 0;
    applyStimulus(ADD, 4'd0, 4'd0, 4'd4, 8'h10, 1, 1, 1, 0, 0);
    applyStimulus(ADD, 4'd4, 4'd4, 4'd5, 8'h00, 0, 1, 0, 0, 0);
    idle(5);
    checkOutput("ld_addr", obs_rd_addr, 32'h10);
    checkOutput("ld_r4", obs[4], {LANES{8'h33}});
    checkOutput("ld_r5", obs[5], {LANES{8'h66}});
    checkOutput("ld_stalls", stall_cnt, 1);

    $display("[TB] store");
    commit_cnt = 0;
    applyStimulus(MOV, 4'd0, 4'd0, 4'd1, 8'h02, 1, 1, 0, 0, 0);
    applyStimulus(MOV, 4'd0, 4'd0, 4'd2, 8'hAB, 1, 1, 0, 0, 0);
    applyStimulus(ADD, 4'd1, 4'd2, 4'd0, 8'h04, 1, 0, 0, 1, 0);
    idle(5);
    checkOutput("st_addr", obs_st_addr, 32'h02020206);
    checkOutput("st_data", obs_st_data, {LANES{8'hAB}});
    checkOutput("st_commits", commit_cnt, 2);

    $display("[TB] flush");
    commit_mask = '0;
    applyStimulus(MOV, 4'd0, 4'd0, 4'd7, 8'h11, 1, 1, 0, 0, 0);
    applyStimulus(ADD, 4'd7, 4'd7, 4'd6, 8'h00, 0, 1, 0, 0, 1);
    applyStimulus(MOV, 4'd0, 4'd0, 4'd8, 8'h22, 1, 1, 0, 0, 0);
    idle(5);
    checkOutput("flush_r6", commit_mask[6], 1'b0);
    checkOutput("flush_r7", commit_mask[7], 1'b1);
    checkOutput("flush_r8", commit_mask[8], 1'b1);
    stall_cnt = 0;
    applyStimulus(ADD, 4'd0, 4'd0, 4'd9, 8'h20, 1, 1, 1, 0, 0);
    applyStimulus(ADD, 4'd9, 4'd9, 4'd10, 8'h00, 0, 1, 0, 0, 1);
    idle(5);
    checkOutput("flush_stall_cnt", stall_cnt, 1);
    checkOutput("flush_stall_r10", obs[10], {LANES{8'h06}});

    $display("[TB] reset mid-stream");
    applyStimulus(SUB, 4'd0, 4'd1, 4'd12, 8'h00, 0, 1, 0, 0, 0);
    idle(5);
    checkOutput("pre_rst_flags", flags_o, 2'b01);
    commit_cnt = 0;
    applyStimulus(MOV, 4'd0, 4'd0, 4'd1, 8'h05, 1, 1, 0, 0, 0);
    applyStimulus(MOV, 4'd0, 4'd0, 4'd2, 8'h06, 1, 1, 0, 0, 0);
    dec_valid = 1'b1;  dec_op = ADD;  dec_ra1 = 4'd1;  dec_ra2 = 4'd2;  dec_wa = 4'd3;
    dec_use_imm = 1'b0;  dec_regwrite = 1'b1;  dec_memread = 1'b0;  dec_memwrite = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    dec_valid = 1'b0;
    reset = 1'b0;
    checkOutput("mid_rst_wb_addr", wb_addr, 4'h0);
    checkOutput("mid_rst_mem_wdata", mem_wdata, 48'h0);
    idle(5);
    checkOutput("mid_rst_commits", commit_cnt, 0);
    checkOutput("mid_rst_flags", flags_o, 2'b00);
    commit_mask = '0;
    applyStimulus(MOV, 4'd0, 4'd1, 4'd11, 8'h00, 0, 1, 0, 0, 0);
    idle(5);
    checkOutput("mid_rst_r11_commit", commit_mask[11], 1'b1);
    checkOutput("mid_rst_r1_read", obs[11], 48'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
